uart_cfg_core: RTL and testbench
================================

# uart_cfg_core

Parametrised UART with run-time-fixed frame format: configurable data width, parity mode and stop-bit count, 16x-oversampled receiver, and TX/RX FIFOs behind valid/ready handshakes. It reports per-character parity and framing errors and RX overrun. It replaces the fixed 8N1 transmit/receive top level wherever a host block streams bytes to or from a serial link.

## Interface
- SYS_CLK_FRP, 50_000_000, system clock frequency in Hz
- BAUDRATE, 115200, line bit rate
- DATA_BITS, 8, data bits per frame, legal range 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, transmitted stop bits, 1 or 2
- FIFO_AWIDTH, 4, each FIFO holds 2^FIFO_AWIDTH entries
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  synchronous, active-low reset
- tx_data  in  DATA_BITS  character to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  TX FIFO not full; a write is accepted on an edge where tx_valid && tx_ready
- tx_level  out  FIFO_AWIDTH+1  TX FIFO occupancy
- tx_busy  out  1  transmitter is not in IDLE
- uart_tx  out  1  serial output, idle high
- uart_rx  in  1  serial input, asynchronous
- rx_data  out  DATA_BITS  head-of-FIFO character
- rx_err  out  2  head-of-FIFO flags: {frame_err, parity_err}
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop; takes effect on an edge where rx_valid && rx_ready
- rx_level  out  FIFO_AWIDTH+1  RX FIFO occupancy
- rx_overrun  out  1  one-cycle pulse when a received character is dropped

## Operation
- Baud tick generator:
  - DIV = (SYS_CLK_FRP + 8*BAUDRATE) / (16*BAUDRATE), integer division.
  - The counter runs 0..DIV-1 and asserts tick for one cycle at DIV-1.
  - One bit period is 16 ticks.
- FIFOs: first-word-fall-through.
  - A push when full is impossible on TX, because tx_ready is low.
  - A pop when empty is ignored.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the level unchanged.
- TX FSM states: IDLE, START, DATA, PARITY, STOP. All transitions happen on ticks only.
  - IDLE -> START on a tick with the TX FIFO non-empty. On that tick the head is popped into the shift register.
  - START and each DATA bit last 16 ticks. Data is sent LSB first.
  - PARITY is entered only if PARITY != 0 and lasts 16 ticks.
    - Even: the bit is ^data.
    - Odd: the bit is ~^data.
  - STOP lasts 16*STOP_BITS ticks, then goes to IDLE. Back-to-back frames have no extra gap.
- RX path:
  - uart_rx passes through a 2-FF synchronizer; both flops reset to 1.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronized high-to-low transition.
  - START: after 8 ticks, sample the line. If high (glitch), return to IDLE. If low, go to DATA.
  - DATA: sample every 16 ticks, bit 0 first. Then PARITY if enabled, then STOP after a further 16 ticks.
  - parity_err = received parity bit differs from the expected bit; always 0 when PARITY = 0.
  - frame_err = stop sample is 0. Only the first stop bit is checked.
  - At the stop sample, {frame_err, parity_err, data} is pushed and the FSM returns to IDLE.
  - If the RX FIFO is full at the stop sample, the character is dropped, rx_overrun pulses, and FIFO contents are unchanged.
  - A line held low after a framing error produces no new frame until it returns high.
- Reset mid-frame: both FSMs go to IDLE, both FIFOs are emptied, and the baud counter restarts. The partial frame is abandoned.

## Timing
- Reset values:
  - uart_tx = 1, tx_ready = 1, tx_busy = 0.
  - tx_level = 0, rx_level = 0, rx_valid = 0, rx_overrun = 0.
  - rx_data = 0, rx_err = 0.
- tx_ready, rx_valid and the level outputs are registered-count derived. They update the cycle after a push or pop.
- rx_data and rx_err are valid whenever rx_valid = 1.
- The start bit appears within DIV cycles of the first write into an empty, idle TX FIFO. It is driven from the cycle after the qualifying tick.
- Frame length on the wire: 16*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) ticks.
- RX latency: rx_valid rises 1 cycle after the stop-bit mid-sample tick.

## Test plan
All scenarios use SYS_CLK_FRP = 1_600_000 and BAUDRATE = 100_000, giving DIV = 1 and 16 clk per bit. Default format is 8N1, FIFO_AWIDTH = 4.
- Loopback (uart_tx -> uart_rx), 8N1, write 0x55 then 0xA3 -> RX pops 0x55 then 0xA3 with rx_err = 00; frames are exactly 160 clk apart; tx_busy falls after the second stop bit.
- 8E1 send 0x07 -> the line bit after D7 is 1; with PARITY = 1 the same bit is 0; loopback rx_err = 00 in both cases.
- 8E1 RX with 0x0F and parity bit 1 driven -> rx_data = 0x0F, rx_err = 01.
- Stop bit driven 0 on 0x3C, then line held low 20 bit-times -> exactly one entry 0x3C with rx_err = 10; rx_level = 1.
- rx_ready = 0, 17 frames received -> rx_level = 16, one rx_overrun pulse at frame 17's stop sample, first 16 values popped in order.
- tx_valid held high with an incrementing count -> tx_ready drops at tx_level = 16; all accepted bytes appear on the wire in order; asserting rst_n = 0 mid-frame -> uart_tx = 1 and both levels = 0 on the next edge.

Source files
------------

// File: rtl/uart_cfg_core.sv
// uart_cfg_core: UART with a build-time frame format (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits). It has a 16x oversampled receiver and first-word-fall-through
// TX and RX FIFOs with per-character {frame_err, parity_err} flags.
//
// Handshakes: a TX write is taken on a rising edge where tx_valid && tx_ready.
// An RX pop is taken on a rising edge where rx_valid && rx_ready.
// tx_data/tx_valid need not be held once accepted.
// rx_data/rx_err are stable while rx_valid is high and no pop happens.

module uart_cfg_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign level_o = count_q;
    // Head is forced to zero while empty so stale storage never shows.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage written on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module uart_cfg_core #(
    parameter int SYS_CLK_FRP = 50_000_000,
    parameter int BAUDRATE    = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_AWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [FIFO_AWIDTH:0] tx_level,
    output logic                 tx_busy,
    output logic                 uart_tx,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic [1:0]           rx_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [FIFO_AWIDTH:0] rx_level,
    output logic                 rx_overrun
);
    localparam int DIV = (SYS_CLK_FRP + 8 * BAUDRATE) / (16 * BAUDRATE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Expected parity bit for a character: even -> XOR of data, odd -> XNOR.
    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ^d : ~^d;
    endfunction

    // ---------------- baud tick ----------------
    logic [CW-1:0] baud_cnt_q;
    logic          tick;

    assign tick = (baud_cnt_q == CW'(DIV - 1));

    // Free-running divider, one tick per 1/16 bit period.
    always_ff @(posedge clk) begin
        if (!rst_n || tick) baud_cnt_q <= '0;
        else                baud_cnt_q <= baud_cnt_q + 1'b1;
    end

    // ---------------- FIFOs ----------------
    logic                 tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_push, rx_full, rx_empty;
    logic [DATA_BITS+1:0] rx_wdata, rx_head;

    uart_cfg_fifo #(.W(DATA_BITS), .AW(FIFO_AWIDTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(tx_valid), .wdata_i(tx_data), .pop_i(tx_pop),
        .rdata_o(tx_head), .level_o(tx_level), .full_o(tx_full), .empty_o(tx_empty)
    );

    uart_cfg_fifo #(.W(DATA_BITS + 2), .AW(FIFO_AWIDTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(rx_push), .wdata_i(rx_wdata), .pop_i(rx_ready),
        .rdata_o(rx_head), .level_o(rx_level), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_data  = rx_head[DATA_BITS-1:0];
    assign rx_err   = rx_head[DATA_BITS+1:DATA_BITS];

    // ---------------- transmitter ----------------
    state_t               tx_state_q, tx_state_d;
    logic [3:0]           tx_tick_q, tx_tick_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;

    // TX state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
        end
    end

    // TX next state: every move happens on a tick; a new frame is loaded straight
    // from the end of STOP so back-to-back characters have no idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        if (tick) begin
            if (tx_state_q == ST_IDLE) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_par_d   = par_bit(tx_head);
                    tx_state_d = ST_START;
                    tx_tick_d  = '0;
                end
            end else if (tx_tick_q != 4'd15) begin
                tx_tick_d = tx_tick_q + 4'd1;
            end else begin
                tx_tick_d = '0;
                case (tx_state_q)
                    ST_START: begin
                        tx_state_d = ST_DATA;
                        tx_bit_d   = '0;
                    end
                    ST_DATA: begin
                        tx_shift_d = tx_shift_q >> 1;
                        if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                            tx_bit_d = '0;
                            if (PARITY != 0) tx_state_d = ST_PARITY;
                            else             tx_state_d = ST_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        tx_state_d = ST_STOP;
                        tx_bit_d   = '0;
                    end
                    ST_STOP: begin
                        if (tx_bit_q != 4'(STOP_BITS - 1)) begin
                            tx_bit_d = tx_bit_q + 4'd1;
                        end else if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_head;
                            tx_par_d   = par_bit(tx_head);
                            tx_state_d = ST_START;
                        end else begin
                            tx_state_d = ST_IDLE;
                        end
                    end
                    default: tx_state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Serial line level for the current TX state.
    always_comb begin
        uart_tx = 1'b1;
        case (tx_state_q)
            ST_START:  uart_tx = 1'b0;
            ST_DATA:   uart_tx = tx_shift_q[0];
            ST_PARITY: uart_tx = tx_par_q;
            default:   uart_tx = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state_q != ST_IDLE);

    // ---------------- receiver ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    state_t               rx_state_q, rx_state_d;
    logic [3:0]           rx_tick_q, rx_tick_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_overrun_d;
    logic                 rx_sample_pt;

    // START samples at half a bit; every later bit one full bit after the previous sample.
    assign rx_sample_pt = tick && (rx_tick_q == ((rx_state_q == ST_START) ? 4'd7 : 4'd15));
    assign rx_wdata     = {~rx_sync_q, rx_perr_q, rx_shift_q};

    // RX state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= ST_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_overrun <= rx_overrun_d;
        end
    end

    // RX next state: a frame starts only on a falling edge, so a line stuck low
    // after a framing error cannot retrigger.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_tick_d    = rx_tick_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_perr_d    = rx_perr_q;
        rx_push      = 1'b0;
        rx_overrun_d = 1'b0;
        if (rx_state_q == ST_IDLE) begin
            if (rx_prev_q && !rx_sync_q) begin
                rx_state_d = ST_START;
                rx_tick_d  = '0;
            end
        end else if (tick) begin
            if (!rx_sample_pt) begin
                rx_tick_d = rx_tick_q + 4'd1;
            end else begin
                rx_tick_d = '0;
                case (rx_state_q)
                    ST_START: begin
                        if (rx_sync_q) begin
                            rx_state_d = ST_IDLE;
                        end else begin
                            rx_state_d = ST_DATA;
                            rx_bit_d   = '0;
                            rx_perr_d  = 1'b0;
                        end
                    end
                    ST_DATA: begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == 4'(DATA_BITS - 1)) begin
                            if (PARITY != 0) rx_state_d = ST_PARITY;
                            else             rx_state_d = ST_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        rx_perr_d  = (rx_sync_q != par_bit(rx_shift_q));
                        rx_state_d = ST_STOP;
                    end
                    ST_STOP: begin
                        if (rx_full) rx_overrun_d = 1'b1;
                        else         rx_push      = 1'b1;
                        rx_state_d = ST_IDLE;
                    end
                    default: rx_state_d = ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cfg_core.sv
// Bench for uart_cfg_core: three instances (8N1, 8E1, 8O1) at 16 clocks per bit.
// A line decoder checks every transmitted frame; a scoreboard checks every RX pop.
`timescale 1ns/1ps
module tb_uart_cfg_core;
  localparam int BIT_T = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data;
  logic [2:0] tx_valid_a;
  logic       rx_ready;
  logic       loop_en;
  logic       drv_line;
  int         sel;

  logic [2:0] tx_ready_a, tx_busy_a, uart_tx_a, rx_valid_a, rx_overrun_a, rx_in_a;
  logic [4:0] tx_level_a [3];
  logic [4:0] rx_level_a [3];
  logic [7:0] rx_data_a [3];
  logic [1:0] rx_err_a [3];

  // Instance 0: no parity, 1: even (PARITY=2), 2: odd (PARITY=1).
  function automatic int par_mode(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 2 : 1);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int PAR = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    assign rx_in_a[g] = loop_en ? uart_tx_a[g] : drv_line;
    uart_cfg_core #(
      .SYS_CLK_FRP(1_600_000), .BAUDRATE(100_000), .DATA_BITS(8),
      .PARITY(PAR), .STOP_BITS(1), .FIFO_AWIDTH(4)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data), .tx_valid(tx_valid_a[g]), .tx_ready(tx_ready_a[g]),
      .tx_level(tx_level_a[g]), .tx_busy(tx_busy_a[g]), .uart_tx(uart_tx_a[g]),
      .uart_rx(rx_in_a[g]),
      .rx_data(rx_data_a[g]), .rx_err(rx_err_a[g]), .rx_valid(rx_valid_a[g]),
      .rx_ready(rx_ready), .rx_level(rx_level_a[g]), .rx_overrun(rx_overrun_a[g])
    );
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [9:0] rx_exp_q[$];   // {frame_err, parity_err, data}
  logic [7:0] tx_exp_q[$];
  time        start_t[$];
  int         frames = 0;
  int         rst_cnt = 0;
  int         ovr_cnt = 0;
  logic       last_par = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (!rst_n) rst_cnt++;
  always @(negedge clk) if (rst_n && rx_overrun_a[sel]) ovr_cnt++;

  // Compare process: every pop against the scoreboard, plus level-derived flags.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tx_ready_vs_level", tx_ready_a[sel], tx_level_a[sel] != 5'd16);
      chk("rx_valid_vs_level", rx_valid_a[sel], rx_level_a[sel] != 5'd0);
      if (rx_valid_a[sel] && rx_ready) begin
        if (rx_exp_q.size() == 0) chk("rx_unexpected_char", {rx_err_a[sel], rx_data_a[sel]}, 32'hFFFF);
        else chk("rx_char", {rx_err_a[sel], rx_data_a[sel]}, rx_exp_q.pop_front());
      end
    end
  end

  // Line decoder: samples uart_tx at bit centres and checks the frame against the model.
  initial begin : line_mon
    int s, rc, ones;
    time t0;
    logic st, p, stp, pe;
    logic [7:0] d, e;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx_a[sel] == 1'b0) begin
        s = sel; rc = rst_cnt; t0 = $time; p = 1'b0;
        repeat (BIT_T / 2) @(negedge clk);
        st = uart_tx_a[s];
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_T) @(negedge clk);
          d[i] = uart_tx_a[s];
        end
        if (par_mode(s) != 0) begin
          repeat (BIT_T) @(negedge clk);
          p = uart_tx_a[s];
        end
        repeat (BIT_T) @(negedge clk);
        stp = uart_tx_a[s];
        if (rc == rst_cnt) begin
          chk("tx_start_bit", st, 0);
          chk("tx_stop_bit", stp, 1);
          ones = $countones(d);
          pe = (par_mode(s) == 2) ? ones[0] : ~ones[0];
          if (par_mode(s) != 0) chk("tx_parity_bit", p, pe);
          if (tx_exp_q.size() == 0) chk("tx_unexpected_frame", d, 32'hFFFF);
          else begin
            e = tx_exp_q.pop_front();
            chk("tx_frame_data", d, e);
          end
          start_t.push_back(t0);
          last_par = p;
          frames++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    tx_valid_a = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tx_write(input logic [7:0] d, input bit rx_too);
    int c = 0;
    tx_data = d;
    tx_valid_a[sel] = 1'b1;
    while (!tx_ready_a[sel] && c < 4000) begin @(posedge clk); #1; c++; end
    chk("tx_write_ready", tx_ready_a[sel], 1);
    @(posedge clk); #1;
    tx_valid_a[sel] = 1'b0;
    tx_exp_q.push_back(d);
    if (rx_too) rx_exp_q.push_back({2'b00, d});
  endtask

  task automatic drive_bit(input logic b);
    drv_line = b;
    repeat (BIT_T) @(posedge clk);
    #1;
  endtask

  // Drives one 8-bit frame on the RX line in the format of instance sel.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_val,
                            input bit expect_it);
    int ones = $countones(d);
    logic pb = (par_mode(sel) == 2) ? ones[0] : ~ones[0];
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_mode(sel) != 0) drive_bit(pb ^ par_flip);
    drive_bit(stop_val);
    if (expect_it)
      rx_exp_q.push_back({~stop_val, (par_mode(sel) != 0) && par_flip, d});
  endtask

  task automatic wait_frames(input int n, input int bound);
    int c = 0;
    while (frames < n && c < bound) begin @(posedge clk); #1; c++; end
    chk("tx_frame_count", frames >= n, 1);
  endtask

  task automatic wait_rx_valid(input int bound);
    int c = 0;
    while (!rx_valid_a[sel] && c < bound) begin @(posedge clk); #1; c++; end
    chk("rx_valid_timeout", rx_valid_a[sel], 1);
  endtask

  task automatic drain(input int bound);
    int c = 0;
    rx_ready = 1'b1;
    while ((rx_exp_q.size() != 0 || rx_valid_a[sel]) && c < bound) begin
      @(posedge clk); #1; c++;
    end
    chk("rx_drain_left", rx_exp_q.size(), 0);
    chk("rx_level_drained", rx_level_a[sel], 0);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int  f0, ov0;
    time tb_fall;
    bit  acc, seen_full;
    sel = 0; loop_en = 1'b0; drv_line = 1'b1; rx_ready = 1'b0;
    tx_data = '0; tx_valid_a = '0; rst_n = 1'b0;

    // Reset values, observed while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_tx", uart_tx_a[0], 1);
    chk("rst_tx_ready", tx_ready_a[0], 1);
    chk("rst_tx_busy", tx_busy_a[0], 0);
    chk("rst_tx_level", tx_level_a[0], 0);
    chk("rst_rx_level", rx_level_a[0], 0);
    chk("rst_rx_valid", rx_valid_a[0], 0);
    chk("rst_rx_overrun", rx_overrun_a[0], 0);
    chk("rst_rx_data", rx_data_a[0], 0);
    chk("rst_rx_err", rx_err_a[0], 0);
    do_reset();

    // 8N1 loopback: 0x55 then 0xA3, frames 160 clk apart, busy falls 160 clk after 2nd start.
    loop_en = 1'b1; rx_ready = 1'b1;
    f0 = frames;
    tx_write(8'h55, 1'b1);
    tx_write(8'hA3, 1'b1);
    wait_frames(f0 + 2, 1000);
    begin
      int c = 0;
      while (tx_busy_a[0] && c < 200) begin @(posedge clk); #1; c++; end
    end
    @(negedge clk);
    tb_fall = $time;
    @(posedge clk); #1;
    if (start_t.size() >= f0 + 2) begin
      chk("frame_spacing_clk", (start_t[f0+1] - start_t[f0]) / 10, 160);
      chk("busy_fall_after_start2", (tb_fall - start_t[f0+1]) / 10, 160);
    end else chk("frame_starts_recorded", start_t.size(), f0 + 2);
    drain(400);

    // 8E1 then 8O1 loopback of 0x07: parity bit 1 for even, 0 for odd.
    sel = 1; do_reset();
    f0 = frames;
    tx_write(8'h07, 1'b1);
    wait_frames(f0 + 1, 1000);
    chk("even_parity_0x07", last_par, 1);
    drain(400);
    sel = 2; do_reset();
    f0 = frames;
    tx_write(8'h07, 1'b1);
    wait_frames(f0 + 1, 1000);
    chk("odd_parity_0x07", last_par, 0);
    drain(400);

    // 8E1 RX: 0x0F with a wrong parity bit (1) -> parity_err only.
    sel = 1; do_reset();
    loop_en = 1'b0; rx_ready = 1'b0;
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
    wait_rx_valid(100);
    chk("perr_rx_data", rx_data_a[1], 8'h0F);
    chk("perr_rx_err", rx_err_a[1], 2'b01);
    drain(100);

    // 8N1 RX: 0x3C with stop bit 0, then the line held low for 20 bit times.
    sel = 0; do_reset();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (20 * BIT_T) @(posedge clk);
    #1;
    drv_line = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("ferr_rx_level", rx_level_a[0], 1);
    chk("ferr_rx_data", rx_data_a[0], 8'h3C);
    chk("ferr_rx_err", rx_err_a[0], 2'b10);
    drain(100);

    // Overrun: 17 frames with rx_ready low -> 16 kept, one overrun pulse.
    rx_ready = 1'b0;
    ov0 = ovr_cnt;
    for (int i = 0; i < 17; i++) send_frame(8'(i * 13 + 5), 1'b0, 1'b1, i < 16);
    repeat (20) @(posedge clk);
    #1;
    chk("ovr_rx_level", rx_level_a[0], 16);
    chk("ovr_pulses", ovr_cnt - ov0, 1);
    drain(200);

    // TX fill with an incrementing count, then reset in the middle of a frame.
    do_reset();
    loop_en = 1'b1; rx_ready = 1'b0; seen_full = 1'b0;
    tx_data = 8'h00;
    tx_valid_a[0] = 1'b1;
    for (int c = 0; c < 600; c++) begin
      acc = tx_ready_a[0];
      if (!acc && !seen_full) begin
        seen_full = 1'b1;
        chk("tx_level_at_full", tx_level_a[0], 16);
      end
      @(posedge clk); #1;
      if (acc) begin
        tx_exp_q.push_back(tx_data);
        tx_data = tx_data + 8'd1;
      end
    end
    tx_valid_a[0] = 1'b0;
    chk("tx_ready_dropped", seen_full, 1);
    wait_frames(frames + 1, 400);
    repeat (40) @(posedge clk);
    #1;
    chk("midframe_tx_busy", tx_busy_a[0], 1);
    chk("midframe_rx_nonempty", rx_level_a[0] != 5'd0, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_uart_tx", uart_tx_a[0], 1);
    chk("midrst_tx_level", tx_level_a[0], 0);
    chk("midrst_rx_level", rx_level_a[0], 0);
    chk("midrst_tx_busy", tx_busy_a[0], 0);
    tx_exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("post_rst_line_idle", uart_tx_a[0], 1);
    chk("rx_scoreboard_empty", rx_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
